// File: rtl/j1p_if.sv
// J1P instruction-fetch and memory-mapped I/O bus bundle.
interface j1p_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PC_WIDTH = 13
);
    logic [PC_WIDTH-1:0] insn_addr;
    logic [15:0]         insn;
    logic                io_rd;
    logic                io_wr;
    logic [WIDTH-1:0]    io_addr;
    logic [WIDTH-1:0]    io_dout;
    logic [WIDTH-1:0]    io_din;
    logic                io_ready;

    modport master (output insn_addr, io_rd, io_wr, io_addr, io_dout,
                    input  insn, io_din, io_ready);
    modport slave  (input  insn_addr, io_rd, io_wr, io_addr, io_dout,
                    output insn, io_din, io_ready);
endinterface

// File: rtl/j1p.sv
// J1P stack CPU core: single-cycle J1-style execution with I/O stall and stack fault tracking.
// Optional interrupt support is enabled by defining J1P_IRQ_EN.
module j1p #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned PC_WIDTH    = 13,
    parameter int unsigned DDEPTH_LOG2 = 5,
    parameter int unsigned RDEPTH_LOG2 = 5,
    parameter logic [12:0] IRQ_VECTOR  = 13'h0002
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_i,
    j1p_if.master                bus,
    output logic [3:0]           fault_o,
    input  logic                 fault_clr_i,
    output logic [DDEPTH_LOG2:0] depth_o
`ifdef J1P_IRQ_EN
    ,
    input  logic                 irq_i,
    output logic                 irq_ack_o
`endif
);
    localparam int unsigned SW     = $clog2(WIDTH);
    localparam int unsigned DDEPTH = 2 ** DDEPTH_LOG2;
    localparam int unsigned RDEPTH = 2 ** RDEPTH_LOG2;
    localparam int unsigned DCW    = DDEPTH_LOG2 + 2;
    localparam int unsigned RCW    = RDEPTH_LOG2 + 2;
    localparam logic signed [DCW-1:0] DMAX = DCW'(DDEPTH);
    localparam logic signed [RCW-1:0] RMAX = RCW'(RDEPTH);

    logic [PC_WIDTH-1:0]    pc, pc_n, pc_plus, call_ret;
    logic [DDEPTH_LOG2-1:0] dsp, dsp_n;
    logic [RDEPTH_LOG2-1:0] rsp, rsp_n;
    logic [WIDTH-1:0]       st0, st0_n, st1, rst0, alu, rstk_d;
    logic [WIDTH-1:0]       dstack [DDEPTH];
    logic [WIDTH-1:0]       rstack [RDEPTH];
    logic [1:0]             dspi, rspi;
    logic                   dstk_we, rstk_we;
    logic [DDEPTH_LOG2:0]   dcnt, dcnt_n;
    logic [RDEPTH_LOG2:0]   rcnt, rcnt_n;
    logic signed [DCW-1:0]  dsum;
    logic signed [RCW-1:0]  rsum;
    logic [3:0]             fault_ev;
    logic [15:0]            ir;
    logic                   take, is_alu, io_rd_c, io_wr_c, stall;
    logic                   unused_ok;

    assign st1  = dstack[dsp];
    assign rst0 = rstack[rsp];

    // Interrupt entry replaces the fetched insn with a call to the vector.
    assign ir = take ? {3'b010, IRQ_VECTOR} : bus.insn;

    assign is_alu  = (ir[15:13] == 3'b011);
    assign io_rd_c = is_alu && (ir[11:8] == 4'hC);
    assign io_wr_c = is_alu && ir[5];
    assign stall   = (io_rd_c || io_wr_c) && !bus.io_ready;

    assign bus.io_rd     = !sys_rst_i && io_rd_c;
    assign bus.io_wr     = !sys_rst_i && io_wr_c;
    assign bus.io_addr   = st0;
    assign bus.io_dout   = st1;
    assign bus.insn_addr = sys_rst_i ? '0 : (stall ? pc : pc_n);
    assign depth_o       = dcnt;
    assign unused_ok     = ir[4];

    // ALU T-select
    always_comb begin
        alu = st0;
        case (ir[11:8])
            4'h0: alu = st0;
            4'h1: alu = st1;
            4'h2: alu = st0 + st1;
            4'h3: alu = st0 & st1;
            4'h4: alu = st0 | st1;
            4'h5: alu = st0 ^ st1;
            4'h6: alu = ~st0;
            4'h7: alu = {WIDTH{st1 == st0}};
            4'h8: alu = {WIDTH{$signed(st1) < $signed(st0)}};
            4'h9: alu = st1 >> st0[SW-1:0];
            4'hA: alu = st0 - WIDTH'(1);
            4'hB: alu = rst0;
            4'hC: alu = bus.io_din;
            4'hD: alu = st1 << st0[SW-1:0];
            4'hE: alu = WIDTH'({rsp, dsp});
            default: alu = {WIDTH{st1 < st0}};
        endcase
    end

    // Instruction decode and next-state
    always_comb begin
        pc_plus  = pc + PC_WIDTH'(1);
        call_ret = take ? pc : pc_plus;
        pc_n     = pc_plus;
        st0_n    = st0;
        dspi     = 2'b00;
        rspi     = 2'b00;
        dstk_we  = 1'b0;
        rstk_we  = 1'b0;
        rstk_d   = WIDTH'({call_ret, 1'b0});
        if (ir[15]) begin
            st0_n   = WIDTH'(ir[14:0]);
            dspi    = 2'b01;
            dstk_we = 1'b1;
        end else begin
            case (ir[14:13])
                2'b00: pc_n = PC_WIDTH'(ir[12:0]);
                2'b01: begin
                    st0_n = st1;
                    dspi  = 2'b11;
                    if (st0 == '0) pc_n = PC_WIDTH'(ir[12:0]);
                end
                2'b10: begin
                    rspi    = 2'b01;
                    rstk_we = 1'b1;
                    pc_n    = PC_WIDTH'(ir[12:0]);
                end
                default: begin
                    st0_n   = alu;
                    dspi    = ir[1:0];
                    rspi    = ir[3:2];
                    dstk_we = ir[7];
                    rstk_we = ir[6];
                    rstk_d  = st0;
                    if (ir[12]) pc_n = rst0[PC_WIDTH:1];
                end
            endcase
        end
    end

    // Pointers wrap; occupancy saturates and flags over/underflow
    always_comb begin
        dsp_n  = dsp + DDEPTH_LOG2'($signed(dspi));
        rsp_n  = rsp + RDEPTH_LOG2'($signed(rspi));
        dsum   = $signed({1'b0, dcnt}) + DCW'($signed(dspi));
        rsum   = $signed({1'b0, rcnt}) + RCW'($signed(rspi));
        dcnt_n = dsum[DCW-1] ? '0 : (dsum > DMAX) ? DMAX[DDEPTH_LOG2:0] : dsum[DDEPTH_LOG2:0];
        rcnt_n = rsum[RCW-1] ? '0 : (rsum > RMAX) ? RMAX[RDEPTH_LOG2:0] : rsum[RDEPTH_LOG2:0];
        fault_ev = '0;
        if (!stall)
            fault_ev = {rsum[RCW-1], (rsum > RMAX), dsum[DCW-1], (dsum > DMAX)};
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            pc      <= '0;
            dsp     <= '0;
            rsp     <= '0;
            st0     <= '0;
            dcnt    <= '0;
            rcnt    <= '0;
            fault_o <= '0;
        end else begin
            if (!stall) begin
                pc   <= pc_n;
                dsp  <= dsp_n;
                rsp  <= rsp_n;
                st0  <= st0_n;
                dcnt <= dcnt_n;
                rcnt <= rcnt_n;
            end
            fault_o <= (fault_clr_i ? 4'b0000 : fault_o) | fault_ev;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i && !stall && dstk_we) dstack[dsp_n] <= st0;
        if (!sys_rst_i && !stall && rstk_we) rstack[rsp_n] <= rstk_d;
    end

`ifdef J1P_IRQ_EN
    logic                   irq_q, irq_pend, irq_svc, stall_raw;
    logic [RDEPTH_LOG2-1:0] irq_rsp;

    // Stall must be judged on the fetched insn, before any replacement
    assign stall_raw = (bus.insn[15:13] == 3'b011) && !bus.io_ready &&
                       ((bus.insn[11:8] == 4'hC) || bus.insn[5]);
    assign take = irq_pend && !irq_svc && !stall_raw;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            irq_q     <= 1'b0;
            irq_pend  <= 1'b0;
            irq_svc   <= 1'b0;
            irq_rsp   <= '0;
            irq_ack_o <= 1'b0;
        end else begin
            irq_q     <= irq_i;
            irq_ack_o <= take;
            irq_pend  <= (irq_pend && !take) || (irq_i && !irq_q);
            if (take) begin
                irq_svc <= 1'b1;
                irq_rsp <= rsp;
            end else if (irq_svc && !stall && (rsp != irq_rsp) && (rsp_n == irq_rsp)) begin
                irq_svc <= 1'b0;
            end
        end
    end
`else
    assign take = 1'b0;
`endif
endmodule

// File: tb/tb_j1p.sv
// Directed self-checking bench for j1p: literals/ALU, call/return, I/O stall, stack faults, 0branch, IRQ.
module tb_j1p;
    localparam int unsigned WIDTH    = 16;
    localparam int unsigned PC_WIDTH = 13;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] fault;
    logic       fault_clr = 1'b0;
    logic [2:0] depth;
`ifdef J1P_IRQ_EN
    logic       irq = 1'b0;
    logic       irq_ack;
`endif
    logic [15:0] mem [8192];
    int n_tests  = 0;
    int n_fail   = 0;
    int wr_count = 0;

    j1p_if #(.WIDTH(WIDTH), .PC_WIDTH(PC_WIDTH)) bus ();

    j1p #(
        .WIDTH(WIDTH), .PC_WIDTH(PC_WIDTH), .DDEPTH_LOG2(2),
        .RDEPTH_LOG2(5), .IRQ_VECTOR(13'h0002)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (rst),
        .bus         (bus),
        .fault_o     (fault),
        .fault_clr_i (fault_clr),
        .depth_o     (depth)
`ifdef J1P_IRQ_EN
        ,
        .irq_i       (irq),
        .irq_ack_o   (irq_ack)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM and completed-write counter
    always @(posedge clk) begin
        bus.insn <= mem[bus.insn_addr];
        if (bus.io_wr && bus.io_ready) wr_count <= wr_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        bus.io_ready = 1'b1;
        bus.io_din   = '0;

        // Reset state, then LIT 5, LIT 7, T+N d-1
        clear_mem();
        mem[0] = 16'h8005; mem[1] = 16'h8007; mem[2] = 16'h6203; mem[3] = 16'h0003;
        rst = 1'b1;
        repeat (2) step();
        check("rst_insn_addr", 32'(bus.insn_addr), 32'h0);
        check("rst_io_rd", 32'(bus.io_rd), 32'h0);
        check("rst_io_wr", 32'(bus.io_wr), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_depth", 32'(depth), 32'h0);
        check("rst_t", 32'(bus.io_addr), 32'h0);
        rst = 1'b0;
        #1;
        check("first_next_pc", 32'(bus.insn_addr), 32'h1);
        step();
        check("lit5_t", 32'(bus.io_addr), 32'h5);
        check("lit5_depth", 32'(depth), 32'h1);
        step();
        check("lit7_t", 32'(bus.io_addr), 32'h7);
        check("lit7_n", 32'(bus.io_dout), 32'h5);
        step();
        check("add_t", 32'(bus.io_addr), 32'hC);
        check("add_depth", 32'(depth), 32'h1);
        check("add_fault", 32'(fault), 32'h0);

        // CALL 0x10 at pc=3, copy R to T, return, then read {rsp,dsp}
        clear_mem();
        mem[0] = 16'h6000; mem[1] = 16'h6000; mem[2] = 16'h6000; mem[3] = 16'h4010;
        mem[4] = 16'h6E00; mem[5] = 16'h0005;
        mem[16] = 16'h6B81; mem[17] = 16'h700C;
        do_reset();
        repeat (3) step();
        check("call_target", 32'(bus.insn_addr), 32'h10);
        step();
        check("in_sub_next", 32'(bus.insn_addr), 32'h11);
        step();
        check("ret_addr_r", 32'(bus.io_addr), 32'h0008);
        check("ret_next_pc", 32'(bus.insn_addr), 32'h4);
        step();
        step();
        check("rsp_dsp_after_ret", 32'(bus.io_addr), 32'h0001);

        // Reset during an I/O stall abandons the access
        clear_mem();
        mem[0] = 16'h8055; mem[1] = 16'h8030; mem[2] = 16'h6A20; mem[3] = 16'h0003;
        bus.io_ready = 1'b0;
        do_reset();
        repeat (3) step();
        check("stall_io_wr", 32'(bus.io_wr), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_abandon_wr", 32'(bus.io_wr), 32'h0);
        check("rst_abandon_addr", 32'(bus.insn_addr), 32'h0);

        // io_wr held 4 cycles with io_ready low for 3
        do_reset();
        wr_count = 0;
        repeat (2) step();
        for (int i = 0; i < 3; i++) begin
            check("stall_wr", 32'(bus.io_wr), 32'h1);
            check("stall_pc", 32'(bus.insn_addr), 32'h2);
            check("stall_t", 32'(bus.io_addr), 32'h30);
            check("stall_n", 32'(bus.io_dout), 32'h55);
            step();
        end
        bus.io_ready = 1'b1;
        #1;
        check("ready_wr", 32'(bus.io_wr), 32'h1);
        check("ready_next_pc", 32'(bus.insn_addr), 32'h3);
        step();
        check("done_t", 32'(bus.io_addr), 32'h2F);
        check("done_wr_low", 32'(bus.io_wr), 32'h0);
        check("single_write", 32'(wr_count), 32'h1);

        // Five literals into a 4-deep data stack
        clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = 16'h8000 | 16'(i + 1);
        mem[5] = 16'h0005;
        do_reset();
        repeat (4) step();
        check("full_depth", 32'(depth), 32'h4);
        check("full_no_fault", 32'(fault), 32'h0);
        step();
        check("over_depth", 32'(depth), 32'h4);
        check("over_fault", 32'(fault), 32'h1);
        check("over_t", 32'(bus.io_addr), 32'h5);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("fault_clr", 32'(fault), 32'h0);

        // 0branch taken / not taken / pop at empty
        clear_mem();
        mem[0] = 16'h8000; mem[1] = 16'h2020;
        mem[32] = 16'h8001; mem[33] = 16'h2030; mem[34] = 16'h2040;
        mem[64] = 16'h0040;
        do_reset();
        step();
        check("zbr_taken_addr", 32'(bus.insn_addr), 32'h20);
        step();
        check("zbr_depth_dec", 32'(depth), 32'h0);
        step();
        check("zbr_not_taken", 32'(bus.insn_addr), 32'h22);
        step();
        check("zbr_taken2", 32'(bus.insn_addr), 32'h40);
        step();
        check("under_fault", 32'(fault), 32'h2);
        check("under_depth", 32'(depth), 32'h0);

`ifdef J1P_IRQ_EN
        // IRQ at pc=6, second edge during the ISR taken after return
        clear_mem();
        mem[0] = 16'h0004; mem[2] = 16'h6000; mem[3] = 16'h700C;
        mem[4] = 16'h6000; mem[5] = 16'h6000; mem[6] = 16'h8009; mem[7] = 16'h0007;
        do_reset();
        repeat (2) step();
        irq = 1'b1;
        step();
        check("irq_vector", 32'(bus.insn_addr), 32'h2);
        step();
        check("irq_ack", 32'(irq_ack), 32'h1);
        check("isr_next", 32'(bus.insn_addr), 32'h3);
        irq = 1'b0;
        step();
        check("irq_ack_pulse", 32'(irq_ack), 32'h0);
        check("irq_ret_pc", 32'(bus.insn_addr), 32'h6);
        irq = 1'b1;
        step();
        check("irq2_vector", 32'(bus.insn_addr), 32'h2);
        step();
        check("irq2_ack", 32'(irq_ack), 32'h1);
        irq = 1'b0;
        repeat (2) step();
        check("irq2_resume", 32'(bus.insn_addr), 32'h7);
        step();
        check("irq_resume_t", 32'(bus.io_addr), 32'h9);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
